// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
// It grants one byte per frame and holds off the next grant until busy and the guard gap end.
module uart_tx_sched #(
   parameter int NUM_REQ    = 4,
   parameter int START_TO   = 8,
   parameter int GAP_CYCLES = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   input  logic [8*NUM_REQ-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   output logic [7:0]             tx_data_o,
   output logic                   tx_wr_o,
   input  logic                   tx_busy_i,
   output logic [NUM_REQ-1:0]     grant_o,
   output logic                   active_o,
   output logic                   err_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_START,
      S_WAIT_END,
      S_GAP
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_last;
   logic [7:0]         r_cnt;
   logic [7:0]         r_tx_data;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_tx_wr;
   logic               r_active;

   logic               w_found;
   logic [IDX_W-1:0]   w_idx;
   logic [IDX_W-1:0]   w_win;
   logic [NUM_REQ-1:0] w_win_oh;
   logic               w_xfer;
   logic               w_timeout;
   logic               w_frame_end;

   // Search starts one past the last winner and wraps, so every requester gets a turn.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = IDX_W'((int'(r_last) + i) % NUM_REQ);
         if (!w_found && req_valid_i[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_win_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
   assign req_ready_o = (rst_n_i && r_state == S_IDLE && w_found) ? w_win_oh : '0;
   assign w_xfer      = |(req_valid_i & req_ready_o);

   // Timeout is decided in the same cycle busy is sampled, so a late busy still wins.
   assign w_timeout   = (r_state == S_WAIT_START) && !tx_busy_i && (r_cnt == 8'(START_TO - 1));
   assign w_frame_end = w_timeout || (r_state == S_WAIT_END && !tx_busy_i);

   assign err_o     = w_timeout;
   assign tx_data_o = r_tx_data;
   assign tx_wr_o   = r_tx_wr;
   assign grant_o   = r_grant;
   assign active_o  = r_active;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= S_IDLE;
         r_last    <= IDX_W'(NUM_REQ - 1);
         r_cnt     <= '0;
         r_tx_data <= '0;
         r_grant   <= '0;
         r_tx_wr   <= 1'b0;
         r_active  <= 1'b0;
      end else begin
         // NOTE: non-blocking for all state so every register sees pre-edge values.
         r_tx_wr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_tx_data <= req_data_i[{w_win, 3'b000} +: 8];
                  r_grant   <= w_win_oh;
                  r_last    <= w_win;
                  r_tx_wr   <= 1'b1;
                  r_active  <= 1'b1;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt   <= '0;
               r_state <= S_WAIT_START;
            end
            S_WAIT_START: begin
               r_cnt <= r_cnt + 8'd1;
               if (tx_busy_i) r_state <= S_WAIT_END;
            end
            S_WAIT_END: ;
            S_GAP: begin
               if (r_cnt == 8'(GAP_CYCLES - 1)) begin
                  r_state  <= S_IDLE;
                  r_grant  <= '0;
                  r_active <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_frame_end) begin
            if (GAP_CYCLES == 0) begin
               r_state  <= S_IDLE;
               r_grant  <= '0;
               r_active <= 1'b0;
            end else begin
               r_state <= S_GAP;
               r_cnt   <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a scoreboard of expected (byte, grant) pairs checked on each write
// pulse, plus directed timing checks for handshake, timeout, guard gap and async reset.
module tb_uart_tx_sched;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid, req_ready, grant;
   logic [8*N-1:0] req_data;
   logic [7:0]     tx_data;
   logic           tx_wr, tx_busy, active, err;

   logic [N-1:0]   g_valid, g_ready, g_grant;
   logic [8*N-1:0] g_data;
   logic [7:0]     g_tx_data;
   logic           g_wr, g_busy, g_active, g_err;

   initial forever #5 clk = ~clk;

   uart_tx_sched #(.NUM_REQ(N), .START_TO(8), .GAP_CYCLES(0)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
      .tx_data_o(tx_data), .tx_wr_o(tx_wr), .tx_busy_i(tx_busy),
      .grant_o(grant), .active_o(active), .err_o(err)
   );

   uart_tx_sched #(.NUM_REQ(N), .START_TO(8), .GAP_CYCLES(3)) dut_gap (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(g_valid), .req_data_i(g_data), .req_ready_o(g_ready),
      .tx_data_o(g_tx_data), .tx_wr_o(g_wr), .tx_busy_i(g_busy),
      .grant_o(g_grant), .active_o(g_active), .err_o(g_err)
   );

   typedef struct packed {
      logic [7:0]   data;
      logic [N-1:0] grant;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   pend[N];
   int   g_pend[N];
   int   n_ready = 0;
   int   n_wr = 0;
   bit   busy_en = 1'b1;
   int   bcnt = 0;
   int   g_bcnt = 0;

   int   base_r, base_w, seen, r0, r1, fall;
   logic prev_b, wr2;
   logic [7:0]   d2;
   logic [N-1:0] gap_grant;
   logic         gap_active;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input int k, input logic [7:0] d, input int n);
      req_data[8*k +: 8] = d;
      pend[k]            = n;
      req_valid[k]       = 1'b1;
   endtask

   task automatic g_send(input int k, input logic [7:0] d, input int n);
      g_data[8*k +: 8] = d;
      g_pend[k]        = n;
      g_valid[k]       = 1'b1;
   endtask

   task automatic push_exp(input logic [7:0] d, input logic [N-1:0] g);
      exp_t e;
      e.data  = d;
      e.grant = g;
      sb.push_back(e);
   endtask

   task automatic wait_done(input string name);
      bit done;
      int left;
      done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         #1;
         left = 0;
         for (int k = 0; k < N; k++) left += pend[k];
         done = (left == 0) && !active && (req_ready == '0) && (sb.size() == 0);
      end
      check({name, "_done"}, 32'(done), 32'd1);
   endtask

   // Producers: a transfer seen at the negedge is retired just after the following posedge.
   initial begin
      logic [N-1:0] x, gx;
      forever begin
         @(negedge clk);
         x  = req_valid & req_ready;
         gx = g_valid & g_ready;
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (x[k]) begin
               pend[k]--;
               if (pend[k] == 0) req_valid[k] = 1'b0;
            end
            if (gx[k]) begin
               g_pend[k]--;
               if (g_pend[k] == 0) g_valid[k] = 1'b0;
            end
         end
      end
   end

   // Transmitter model: busy rises the cycle after the write pulse and stays high for a fixed length.
   initial begin
      forever begin
         @(negedge clk);
         if (tx_wr && busy_en) bcnt = 10;
         if (g_wr) g_bcnt = 4;
         @(posedge clk);
         #1;
         tx_busy = (bcnt > 0);
         if (bcnt > 0) bcnt--;
         g_busy = (g_bcnt > 0);
         if (g_bcnt > 0) g_bcnt--;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (req_ready != '0) begin
            n_ready++;
            check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
            check("ready_has_valid", 32'(|(req_ready & req_valid)), 32'd1);
         end
         if (tx_wr) begin
            n_wr++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wr: actual data=0x%0h grant=%b required no write", tx_data, grant);
            end else begin
               e = sb.pop_front();
               check("wr_data", 32'(tx_data), 32'(e.data));
               check("wr_grant", 32'(grant), 32'(e.grant));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b1;
      req_valid = '0; req_data = '0; g_valid = '0; g_data = '0;
      tx_busy = 1'b0; g_busy = 1'b0;
      for (int k = 0; k < N; k++) begin
         pend[k]   = 0;
         g_pend[k] = 0;
      end
      #1 rst_n = 1'b0;
      #2;
      check("rst_tx_data", 32'(tx_data), 32'h0);
      check("rst_tx_wr", 32'(tx_wr), 32'h0);
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_active", 32'(active), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready_none", 32'(req_ready), 32'h0);

      // All four valid: rotation 0,1,2,3,0 with one ready per frame.
      @(posedge clk); #2;
      for (int k = 0; k < N; k++) send(k, 8'h10 + 8'(k), (k == 0) ? 2 : 1);
      push_exp(8'h10, 4'b0001);
      push_exp(8'h11, 4'b0010);
      push_exp(8'h12, 4'b0100);
      push_exp(8'h13, 4'b1000);
      push_exp(8'h10, 4'b0001);
      base_r = n_ready;
      base_w = n_wr;
      wait_done("t2");
      check("t2_ready_count", 32'(n_ready - base_r), 32'd5);
      check("t2_wr_count", 32'(n_wr - base_w), 32'd5);

      // Single requester: handshake latency and the tail of the frame.
      @(posedge clk); #2;
      send(0, 8'hA5, 1);
      push_exp(8'hA5, 4'b0001);
      @(negedge clk);
      check("t1_ready0", 32'(req_ready), 32'b0001);
      @(negedge clk);
      check("t1_wr", 32'(tx_wr), 32'd1);
      check("t1_ready_drop", 32'(req_ready), 32'h0);
      repeat (11) @(negedge clk);
      check("t1_active_hold", 32'(active), 32'd1);
      @(negedge clk);
      check("t1_active_fall", 32'(active), 32'd0);
      check("t1_grant_clear", 32'(grant), 32'h0);
      check("t1_data_hold", 32'(tx_data), 32'hA5);

      // Last grant 2, then req1 and req2 together: search 3,0,1 picks req1.
      @(posedge clk); #2;
      send(2, 8'h22, 1);
      push_exp(8'h22, 4'b0100);
      wait_done("t3a");
      @(posedge clk); #2;
      send(1, 8'h41, 1);
      send(2, 8'h42, 1);
      push_exp(8'h41, 4'b0010);
      push_exp(8'h42, 4'b0100);
      wait_done("t3b");

      // Busy never rises: err on the 8th WAIT_START cycle, then normal service.
      busy_en = 1'b0;
      @(posedge clk); #2;
      send(3, 8'h5C, 1);
      push_exp(8'h5C, 4'b1000);
      @(negedge clk);
      @(negedge clk);
      check("t4_wr", 32'(tx_wr), 32'd1);
      seen = 0;
      repeat (7) begin
         @(negedge clk);
         if (err) seen++;
      end
      check("t4_no_early_err", 32'(seen), 32'd0);
      @(negedge clk);
      check("t4_err_pulse", 32'(err), 32'd1);
      @(negedge clk);
      check("t4_err_clear", 32'(err), 32'd0);
      check("t4_idle", 32'(active), 32'd0);
      check("t4_grant_clear", 32'(grant), 32'h0);
      busy_en = 1'b1;
      @(posedge clk); #2;
      send(0, 8'h77, 1);
      push_exp(8'h77, 4'b0001);
      wait_done("t4_next");

      // Reset during WAIT_END: outputs clear at once, then req3 alone is granted.
      @(posedge clk); #2;
      send(1, 8'h3C, 1);
      push_exp(8'h3C, 4'b0010);
      for (int i = 0; i < 20 && !tx_wr; i++) @(negedge clk);
      check("t6_wr_seen", 32'(tx_wr), 32'd1);
      repeat (3) @(negedge clk);
      check("t6_active_pre", 32'(active), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_tx_data", 32'(tx_data), 32'h0);
      check("t6_rst_tx_wr", 32'(tx_wr), 32'h0);
      check("t6_rst_ready", 32'(req_ready), 32'h0);
      check("t6_rst_grant", 32'(grant), 32'h0);
      check("t6_rst_active", 32'(active), 32'h0);
      check("t6_rst_err", 32'(err), 32'h0);
      repeat (12) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;
      send(3, 8'hC3, 1);
      push_exp(8'hC3, 4'b1000);
      wait_done("t6_after");

      // Guard gap of 3 on the second instance: busy falls, three idle cycles, then ready.
      r0 = -1; r1 = -1; fall = -1; prev_b = 1'b0;
      wr2 = 1'b0; d2 = '0; gap_grant = '0; gap_active = 1'b0;
      @(posedge clk); #2;
      g_send(0, 8'h50, 1);
      g_send(1, 8'h51, 1);
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (g_ready == 4'b0001 && r0 < 0) r0 = c;
         if (g_ready == 4'b0010 && r1 < 0) r1 = c;
         if (prev_b && !g_busy && fall < 0) fall = c;
         if (fall >= 0 && c == fall + 2) begin
            gap_grant  = g_grant;
            gap_active = g_active;
         end
         if (r1 >= 0 && c == r1 + 1) begin
            wr2 = g_wr;
            d2  = g_tx_data;
            break;
         end
         prev_b = g_busy;
      end
      check("t5_first_ready", 32'(r0), 32'd0);
      check("t5_busy_fall", 32'(fall), 32'd6);
      check("t5_gap_to_ready", 32'(r1 - fall), 32'd4);
      check("t5_grant_in_gap", 32'(gap_grant), 32'b0001);
      check("t5_active_in_gap", 32'(gap_active), 32'd1);
      check("t5_second_wr", 32'(wr2), 32'd1);
      check("t5_second_byte", 32'(d2), 32'h51);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
